// File: rtl/rs_issue_queue_pkg.sv
// rs_pkg: shared types, widths and the ROB age helper for the reservation station.
package rs_pkg;
    localparam int XLEN = 32;
    localparam int PREG_W = 6;
    localparam int ROB_W = 4;
    localparam int FU_W = 2;
    localparam logic [6:0] OP_ADDI = 7'h13;
    localparam logic [6:0] OP_ADD = 7'h33;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] func3;
        logic [6:0] func7;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [ROB_W-1:0] rob_idx;
        logic [FU_W-1:0] fu_idx;
        logic [XLEN-1:0] src1_data;
        logic [XLEN-1:0] src2_data;
        logic src1_ready;
        logic src2_ready;
    } rs_uop_t;

    typedef struct packed {
        logic [6:0] op;
        logic [2:0] func3;
        logic [6:0] func7;
        logic [XLEN-1:0] src1_data;
        logic [XLEN-1:0] src2_data;
        logic [PREG_W-1:0] pd;
        logic [ROB_W-1:0] rob_idx;
    } rs_issue_t;

    typedef struct packed {
        logic valid;
        rs_uop_t uop;
    } rs_entry_t;

    // Distance from the ROB head; wraps so the head itself is age 0.
    function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx, input logic [ROB_W-1:0] head);
        return idx - head;
    endfunction
endpackage

// File: rtl/rs_issue_queue_age_select.sv
// rs_age_select: picks the youngest-age (oldest instruction) eligible entry, lower index on ties.
module rs_age_select import rs_pkg::*; #(
    parameter int DEPTH = 16
) (
    input logic [DEPTH-1:0] elig,
    input logic [DEPTH-1:0][ROB_W-1:0] age,
    output logic [DEPTH-1:0] grant,
    output logic [$clog2(DEPTH)-1:0] idx
);
    localparam int IW = $clog2(DEPTH);
    logic [ROB_W-1:0] best;

    always_comb begin
        grant = '0;
        idx = '0;
        best = '0;
        for (int i = 0; i < DEPTH; i++)
            if (elig[i] && (grant == '0 || age[i] < best)) begin
                grant = '0;
                grant[i] = 1'b1;
                idx = IW'(i);
                best = age[i];
            end
    end
endmodule

// File: rtl/rs_issue_queue.sv
// rs_issue_queue: reservation station with CDB wakeup, lowest-free-slot allocation and per-FU oldest-first issue.
module rs_issue_queue import rs_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int DISPATCH_W = 2,
    parameter int NUM_FU = 3,
    parameter int CDB_W = 3
) (
    input logic clk,
    input logic rst,
    input logic flush,
    input logic [ROB_W-1:0] rob_head,
    input logic [DISPATCH_W-1:0] disp_valid,
    output logic disp_ready,
    input rs_uop_t [DISPATCH_W-1:0] disp_uop,
    input logic [CDB_W-1:0] cdb_valid,
    input logic [CDB_W-1:0][PREG_W-1:0] cdb_tag,
    input logic [CDB_W-1:0][XLEN-1:0] cdb_data,
    output logic [NUM_FU-1:0] iss_valid,
    input logic [NUM_FU-1:0] iss_ready,
    output rs_issue_t [NUM_FU-1:0] iss_uop,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);

    rs_entry_t [DEPTH-1:0] q, nxt;
    logic [NUM_FU-1:0][DEPTH-1:0] elig, grant;
    logic [DEPTH-1:0][ROB_W-1:0] age;
    logic [NUM_FU-1:0][IW-1:0] sel;
    logic [OCC_W-1:0] occ_n;
    logic [DEPTH-1:0] used;
    logic placed;
    rs_uop_t u;

    assign disp_ready = 32'(occupancy) + 32'(DISPATCH_W) <= 32'(DEPTH);

    always_comb
        for (int i = 0; i < DEPTH; i++) begin
            age[i] = rob_age(q[i].uop.rob_idx, rob_head);
            for (int k = 0; k < NUM_FU; k++)
                elig[k][i] = q[i].valid && q[i].uop.src1_ready && q[i].uop.src2_ready && q[i].uop.fu_idx == FU_W'(k);
        end

    for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
        rs_age_select #(.DEPTH(DEPTH)) u_sel (.elig(elig[k]), .age(age), .grant(grant[k]), .idx(sel[k]));
        assign iss_valid[k] = |elig[k];
        assign iss_uop[k] = iss_valid[k] ? rs_issue_t'{op: q[sel[k]].uop.op, func3: q[sel[k]].uop.func3,
            func7: q[sel[k]].uop.func7, src1_data: q[sel[k]].uop.src1_data, src2_data: q[sel[k]].uop.src2_data,
            pd: q[sel[k]].uop.pd, rob_idx: q[sel[k]].uop.rob_idx} : '0;
    end

    // Descending CDB loops make the lowest matching port the final write.
    always_comb begin
        nxt = q;
        occ_n = occupancy;
        used = '0;
        placed = 1'b0;
        u = '0;
        for (int i = 0; i < DEPTH; i++) begin
            used[i] = q[i].valid;
            for (int j = CDB_W-1; j >= 0; j--) begin
                if (q[i].valid && !q[i].uop.src1_ready && cdb_valid[j] && cdb_tag[j] == q[i].uop.ps1) begin
                    nxt[i].uop.src1_ready = 1'b1;
                    nxt[i].uop.src1_data = cdb_data[j];
                end
                if (q[i].valid && !q[i].uop.src2_ready && cdb_valid[j] && cdb_tag[j] == q[i].uop.ps2) begin
                    nxt[i].uop.src2_ready = 1'b1;
                    nxt[i].uop.src2_data = cdb_data[j];
                end
            end
        end
        for (int k = 0; k < NUM_FU; k++)
            if (iss_valid[k] && iss_ready[k]) begin
                for (int i = 0; i < DEPTH; i++)
                    if (grant[k][i])
                        nxt[i].valid = 1'b0;
                occ_n = occ_n - 1'b1;
            end
        // Allocation only looks at registered valids, so a slot freed by issue this cycle is not reused yet.
        if (disp_ready)
            for (int s = 0; s < DISPATCH_W; s++)
                if (disp_valid[s]) begin
                    u = disp_uop[s];
                    for (int j = CDB_W-1; j >= 0; j--) begin
                        if (!disp_uop[s].src1_ready && cdb_valid[j] && cdb_tag[j] == disp_uop[s].ps1) begin
                            u.src1_ready = 1'b1;
                            u.src1_data = cdb_data[j];
                        end
                        if (!disp_uop[s].src2_ready && cdb_valid[j] && cdb_tag[j] == disp_uop[s].ps2) begin
                            u.src2_ready = 1'b1;
                            u.src2_data = cdb_data[j];
                        end
                    end
                    placed = 1'b0;
                    for (int i = 0; i < DEPTH; i++)
                        if (!used[i] && !placed) begin
                            nxt[i] = rs_entry_t'{valid: 1'b1, uop: u};
                            used[i] = 1'b1;
                            placed = 1'b1;
                        end
                    occ_n = occ_n + 1'b1;
                end
    end

    always_ff @(posedge clk)
        if (rst || flush) begin
            q <= '0;
            occupancy <= '0;
        end else begin
            q <= nxt;
            occupancy <= occ_n;
        end
endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue: scoreboard bench; expected issues are queued per FU at dispatch and popped on handshake.
module tb_rs_issue_queue;
    import rs_pkg::*;

    logic clk = 0;
    logic rst, flush;
    logic [ROB_W-1:0] rob_head;
    logic [1:0] disp_valid;
    logic disp_ready;
    rs_uop_t [1:0] disp_uop;
    logic [2:0] cdb_valid;
    logic [2:0][PREG_W-1:0] cdb_tag;
    logic [2:0][XLEN-1:0] cdb_data;
    logic [2:0] iss_valid, iss_ready;
    rs_issue_t [2:0] iss_uop;
    logic [4:0] occupancy;

    int total = 0;
    int bad = 0;
    rs_issue_t exp_q [3][$];

    always #5 clk = ~clk;

    rs_issue_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_uop(disp_uop),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_uop(iss_uop),
        .occupancy(occupancy)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rs_uop_t mk(input logic [6:0] op, input int rob, input int fu, input int ps1, input logic r1,
                                   input int d1, input int ps2, input logic r2, input int d2);
        rs_uop_t v;
        v = '0;
        v.op = op;
        v.func3 = 3'(rob);
        v.func7 = 7'(rob + 1);
        v.pd = PREG_W'(rob + 10);
        v.ps1 = PREG_W'(ps1);
        v.ps2 = PREG_W'(ps2);
        v.rob_idx = ROB_W'(rob);
        v.fu_idx = FU_W'(fu);
        v.src1_data = XLEN'(d1);
        v.src2_data = XLEN'(d2);
        v.src1_ready = r1;
        v.src2_ready = r2;
        return v;
    endfunction

    function automatic rs_issue_t mk_iss(input rs_uop_t v, input int d1, input int d2);
        return rs_issue_t'{op: v.op, func3: v.func3, func7: v.func7, src1_data: XLEN'(d1),
                           src2_data: XLEN'(d2), pd: v.pd, rob_idx: v.rob_idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input rs_uop_t a, input rs_uop_t b, input logic [1:0] v);
        disp_uop[0] = a;
        disp_uop[1] = b;
        disp_valid = v;
        tick();
        disp_valid = '0;
    endtask

    // Handshakes during flush/reset are dropped by the DUT, so nothing is popped then.
    always @(negedge clk)
        if (!rst && !flush)
            for (int k = 0; k < 3; k++)
                if (iss_valid[k] && iss_ready[k]) begin
                    if (exp_q[k].size() == 0)
                        check($sformatf("unexpected_iss%0d", k), 128'(iss_uop[k]), 128'(0));
                    else
                        check($sformatf("iss%0d", k), 128'(iss_uop[k]), 128'(exp_q[k].pop_front()));
                end

    initial begin
        rs_uop_t a, b, c;
        rst = 1; flush = 0; rob_head = 0; disp_valid = 0; disp_uop = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_data = '0; iss_ready = 0;
        tick();
        tick();
        check("rst_occ", 128'(occupancy), 128'(0));
        check("rst_ready", 128'(disp_ready), 128'(1));
        check("rst_iss_valid", 128'(iss_valid), 128'(0));
        check("rst_uop0", 128'(iss_uop[0]), 128'(0));
        check("rst_uop2", 128'(iss_uop[2]), 128'(0));
        rst = 0;

        iss_ready = 3'b111;
        a = mk(OP_ADDI, 0, 0, 1, 1, 10, 0, 1, 20);
        b = mk(OP_ADDI, 1, 1, 2, 1, 30, 0, 1, 40);
        exp_q[0].push_back(mk_iss(a, 10, 20));
        exp_q[1].push_back(mk_iss(b, 30, 40));
        disp(a, b, 2'b11);
        check("t1_iss_valid", 128'(iss_valid), 128'(3'b011));
        check("t1_occ", 128'(occupancy), 128'(2));
        tick();
        check("t1_occ_after", 128'(occupancy), 128'(0));
        check("t1_iss_idle", 128'(iss_valid), 128'(0));

        iss_ready = 0;
        for (int p = 0; p < 8; p++) begin
            if (p == 7)
                check("t2_ready_at14", 128'(disp_ready), 128'(1));
            disp(mk(OP_ADD, 2*p, 2, 60, 0, 0, 61, 1, 0), mk(OP_ADD, 2*p+1, 2, 61, 0, 0, 60, 0, 0), 2'b11);
        end
        check("t2_occ_full", 128'(occupancy), 128'(16));
        check("t2_ready_full", 128'(disp_ready), 128'(0));
        disp(mk(OP_ADDI, 3, 0, 1, 1, 1, 1, 1, 1), mk(OP_ADDI, 4, 0, 1, 1, 1, 1, 1, 1), 2'b11);
        check("t2_ignored", 128'(occupancy), 128'(16));
        check("t2_no_iss", 128'(iss_valid), 128'(0));
        flush = 1;
        tick();
        flush = 0;
        check("t2_flushed", 128'(occupancy), 128'(0));

        iss_ready = 3'b111;
        a = mk(OP_ADD, 5, 0, 7, 0, 0, 2, 1, 3);
        exp_q[0].push_back(mk_iss(a, 32'h55, 3));
        cdb_valid = 3'b110;
        cdb_tag[1] = 7; cdb_data[1] = 32'h55;
        cdb_tag[2] = 7; cdb_data[2] = 32'h99;
        disp(a, '0, 2'b01);
        cdb_valid = 0;
        check("t3_bypass_valid", 128'(iss_valid), 128'(3'b001));
        tick();
        b = mk(OP_ADD, 6, 1, 9, 0, 0, 9, 0, 0);
        disp('0, b, 2'b10);
        check("t3_wait_valid", 128'(iss_valid), 128'(0));
        check("t3_wait_occ", 128'(occupancy), 128'(1));
        exp_q[1].push_back(mk_iss(b, 32'hAA, 32'hAA));
        cdb_valid = 3'b101;
        cdb_tag[0] = 9; cdb_data[0] = 32'hAA;
        cdb_tag[2] = 9; cdb_data[2] = 32'hBB;
        tick();
        cdb_valid = 0;
        check("t3_woken_valid", 128'(iss_valid), 128'(3'b010));
        tick();
        check("t3_occ", 128'(occupancy), 128'(0));

        iss_ready = 0;
        rob_head = 14;
        a = mk(OP_ADD, 15, 0, 1, 1, 15, 1, 1, 0);
        b = mk(OP_ADD, 1, 0, 1, 1, 1, 1, 1, 0);
        c = mk(OP_ADD, 14, 0, 1, 1, 14, 1, 1, 0);
        disp(a, b, 2'b11);
        disp(c, '0, 2'b01);
        exp_q[0].push_back(mk_iss(c, 14, 0));
        exp_q[0].push_back(mk_iss(a, 15, 0));
        exp_q[0].push_back(mk_iss(b, 1, 0));
        check("t4_oldest", 128'(iss_uop[0].rob_idx), 128'(14));
        iss_ready = 3'b001;
        tick();
        tick();
        tick();
        iss_ready = 0;
        check("t4_occ", 128'(occupancy), 128'(0));

        rob_head = 0;
        a = mk(OP_ADDI, 3, 0, 1, 1, 33, 1, 1, 44);
        disp(a, '0, 2'b01);
        for (int i = 0; i < 3; i++) begin
            check("t5_hold_valid", 128'(iss_valid[0]), 128'(1));
            check("t5_hold_rob", 128'(iss_uop[0].rob_idx), 128'(3));
            check("t5_hold_occ", 128'(occupancy), 128'(1));
            tick();
        end
        exp_q[0].push_back(mk_iss(a, 33, 44));
        iss_ready = 3'b001;
        tick();
        iss_ready = 0;
        check("t5_freed", 128'(occupancy), 128'(0));

        disp(mk(OP_ADDI, 0, 0, 1, 1, 0, 1, 1, 0), mk(OP_ADDI, 1, 0, 1, 1, 0, 1, 1, 0), 2'b11);
        disp(mk(OP_ADDI, 2, 0, 1, 1, 0, 1, 1, 0), mk(OP_ADDI, 3, 1, 1, 1, 0, 1, 1, 0), 2'b11);
        disp(mk(OP_ADDI, 4, 2, 1, 1, 0, 1, 1, 0), '0, 2'b01);
        check("t6_occ5", 128'(occupancy), 128'(5));
        flush = 1;
        iss_ready = 3'b111;
        disp(mk(OP_ADDI, 5, 0, 1, 1, 0, 1, 1, 0), mk(OP_ADDI, 6, 1, 1, 1, 0, 1, 1, 0), 2'b11);
        flush = 0;
        iss_ready = 0;
        check("t6_occ", 128'(occupancy), 128'(0));
        check("t6_iss", 128'(iss_valid), 128'(0));
        check("t6_ready", 128'(disp_ready), 128'(1));

        disp(mk(OP_ADDI, 7, 2, 1, 1, 0, 1, 1, 0), '0, 2'b01);
        rst = 1;
        tick();
        rst = 0;
        check("t7_rst_occ", 128'(occupancy), 128'(0));
        check("t7_rst_iss", 128'(iss_valid), 128'(0));

        for (int k = 0; k < 3; k++)
            check($sformatf("drain%0d", k), 128'(exp_q[k].size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
